// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the multi-channel PWM block.
package pwm_pkg;
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CMP  = 2'd1,
    SEL_TOP  = 2'd2,
    SEL_CNT  = 2'd3
  } sel_e;

  // Wide reset patterns; users truncate to WIDTH.
  localparam logic [63:0] CNT_RST = '0;
  localparam logic [63:0] TOP_RST = '1;
  localparam logic [63:0] CMP_RST = '0;

  function automatic int ch_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_multi_if.sv
// Register-write bus and PWM status/outputs. PWM_CENTER_ALIGN_EN adds the center select.
interface pwm_multi_if
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int CHW = ch_bits(CHANNELS);

  logic                en;
  logic [WIDTH-1:0]    d;
  sel_e                sel;
  logic [CHW-1:0]      ch;
`ifdef PWM_CENTER_ALIGN_EN
  logic                center;
`endif
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    top;
  logic [CHANNELS-1:0] out;
  logic                period_end;

`ifdef PWM_CENTER_ALIGN_EN
  modport master (output en, d, sel, ch, center, input cnt, top, out, period_end);
  modport slave  (input en, d, sel, ch, center, output cnt, top, out, period_end);
`else
  modport master (output en, d, sel, ch, input cnt, top, out, period_end);
  modport slave  (input en, d, sel, ch, output cnt, top, out, period_end);
`endif
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active compare pair and the registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             xfer,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] cnt_nxt,
  output logic             out
);
  logic [WIDTH-1:0] cmp_sh, cmp_act, cmp_act_nxt;

  // A write coinciding with a transfer bypasses the shadow.
  always_comb begin
    cmp_act_nxt = cmp_act;
    if (xfer) cmp_act_nxt = wr ? d : cmp_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_sh  <= WIDTH'(CMP_RST);
      cmp_act <= WIDTH'(CMP_RST);
      out     <= 1'b0;
    end else begin
      if (wr) cmp_sh <= d;
      cmp_act <= cmp_act_nxt;
      out     <= (cnt_nxt < cmp_act_nxt);
    end
  end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered top/compare.
// PWM_CENTER_ALIGN_EN enables up/down (center-aligned) counting.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus
);
  localparam int CHW = ch_bits(CHANNELS);

  logic [WIDTH-1:0] cnt_q, cnt_nxt, top_sh, top_act, top_act_nxt;
  logic             wrap, xfer, pe_q, wr_cnt, wr_top;
`ifdef PWM_CENTER_ALIGN_EN
  logic             dir_dn, dir_dn_nxt, ctr_act, ctr_act_nxt;
`endif

  assign wr_cnt = (bus.sel == SEL_CNT);
  assign wr_top = (bus.sel == SEL_TOP);

  always_comb begin
    cnt_nxt = cnt_q;
    wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_dn_nxt = dir_dn;
    if (wr_cnt) begin
      cnt_nxt = bus.d;
    end else if (bus.en) begin
      if (ctr_act && !dir_dn) begin
        if (cnt_q >= top_act) begin
          // top=0 degenerates to a one-cycle period, like edge mode
          if (top_act == '0) begin
            wrap    = 1'b1;
            cnt_nxt = '0;
          end else begin
            dir_dn_nxt = 1'b1;
            cnt_nxt    = top_act - WIDTH'(1);
          end
        end else begin
          cnt_nxt = cnt_q + WIDTH'(1);
        end
      end else if (ctr_act) begin
        if (cnt_q == '0) begin
          wrap       = 1'b1;
          dir_dn_nxt = 1'b0;
          cnt_nxt    = (top_act == '0) ? '0 : WIDTH'(1);
        end else begin
          cnt_nxt = cnt_q - WIDTH'(1);
        end
      end else if (cnt_q >= top_act) begin
        wrap       = 1'b1;
        dir_dn_nxt = 1'b0;
        cnt_nxt    = '0;
      end else begin
        cnt_nxt = cnt_q + WIDTH'(1);
      end
    end
`else
    if (wr_cnt) begin
      cnt_nxt = bus.d;
    end else if (bus.en) begin
      if (cnt_q >= top_act) begin
        wrap    = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt_q + WIDTH'(1);
      end
    end
`endif
  end

  // A stopped counter transfers every cycle so writes apply at once.
  assign xfer        = wrap | ~bus.en;
  assign top_act_nxt = xfer ? (wr_top ? bus.d : top_sh) : top_act;
`ifdef PWM_CENTER_ALIGN_EN
  assign ctr_act_nxt = xfer ? bus.center : ctr_act;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= WIDTH'(CNT_RST);
      top_sh  <= WIDTH'(TOP_RST);
      top_act <= WIDTH'(TOP_RST);
      pe_q    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_dn  <= 1'b0;
      ctr_act <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_nxt;
      if (wr_top) top_sh <= bus.d;
      top_act <= top_act_nxt;
      pe_q    <= wrap;
`ifdef PWM_CENTER_ALIGN_EN
      dir_dn  <= dir_dn_nxt;
      ctr_act <= ctr_act_nxt;
`endif
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr      ((bus.sel == SEL_CMP) && (bus.ch == CHW'(i))),
      .xfer    (xfer),
      .d       (bus.d),
      .cnt_nxt (cnt_nxt),
      .out     (bus.out[i])
    );
  end

  assign bus.cnt        = cnt_q;
  assign bus.top        = top_act;
  assign bus.period_end = pe_q;
endmodule
